// File: rtl/dp_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dp_arb_pkg                                                      |
// | Purpose : Shared types for the datapath arbiter: op encoding, packed      |
// |           command layout, controller states, registered output bundle,   |
// |           and helpers mapping (state, command) to datapath controls.     |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package dp_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int REG_W  = 4;
  localparam int FN_W   = 3;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_ALU   = 2'b11
  } op_t;

  // Bit layout: op[24:23] fn[22:20] ra[19:16] rb[15:12] rw[11:8] addr[7:0]
  typedef struct packed {
    op_t               op;
    logic [FN_W-1:0]   fn;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rw;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NOP    = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_STORE  = 3'd4,
    S_ALU    = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr;
    logic              rf_s;
    logic [REG_W-1:0]  ra_addr;
    logic [REG_W-1:0]  rb_addr;
    logic              w_en;
    logic [REG_W-1:0]  w_addr;
    logic [FN_W-1:0]   alu_s;
  } dp_out_t;

  // First execute state entered for a freshly accepted op.
  function automatic state_t op_state(op_t op);
    state_t s;
    case (op)
      OP_LOAD:  s = S_LOAD_A;
      OP_STORE: s = S_STORE;
      OP_ALU:   s = S_ALU;
      default:  s = S_NOP;
    endcase
    return s;
  endfunction

  // Datapath controls to present while sitting in state s.
  function automatic dp_out_t dp_outputs(state_t s, cmd_t c);
    dp_out_t o;
    o = '0;
    case (s)
      S_LOAD_A: begin
        o.d_addr = c.addr;
        o.rf_s   = 1'b1;
      end
      S_LOAD_B: begin
        o.d_addr = c.addr;
        o.rf_s   = 1'b1;
        o.w_en   = 1'b1;
        o.w_addr = c.rw;
      end
      S_STORE: begin
        o.d_addr  = c.addr;
        o.ra_addr = c.ra;
        o.d_wr    = 1'b1;
      end
      S_ALU: begin
        o.ra_addr = c.ra;
        o.rb_addr = c.rb;
        o.alu_s   = c.fn;
        o.w_en    = 1'b1;
        o.w_addr  = c.rw;
      end
      default: ;
    endcase
    return o;
  endfunction

  // States that are the last execute cycle of a command (carry Done).
  function automatic logic is_final(state_t s);
    return (s == S_NOP) || (s == S_LOAD_B) || (s == S_STORE) || (s == S_ALU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : datapath_arbiter_if                                            |
// | Purpose : Bundle of requester handshake and datapath control signals.    |
// | Ports   : Req_Valid/Req_Cmd0/Req_Cmd1 (requesters -> arbiter),           |
// |           Req_Ready/Done/Busy and datapath controls (arbiter -> out).     |
// |           Modport slave = arbiter side, master = requester/datapath side.|
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface datapath_arbiter_if;
  import dp_arb_pkg::*;

  logic [1:0]        Req_Valid;
  cmd_t              Req_Cmd0;
  cmd_t              Req_Cmd1;
  logic [1:0]        Req_Ready;
  logic [1:0]        Done;
  logic              Busy;
  logic [ADDR_W-1:0] D_Addr;
  logic              D_Wr;
  logic              RF_s;
  logic [REG_W-1:0]  RF_Ra_Addr;
  logic [REG_W-1:0]  RF_Rb_Addr;
  logic              RF_W_en;
  logic [REG_W-1:0]  RF_W_Addr;
  logic [FN_W-1:0]   ALU_s0;

  modport slave (
    input  Req_Valid, Req_Cmd0, Req_Cmd1,
    output Req_Ready, Done, Busy, D_Addr, D_Wr, RF_s,
           RF_Ra_Addr, RF_Rb_Addr, RF_W_en, RF_W_Addr, ALU_s0
  );

  modport master (
    output Req_Valid, Req_Cmd0, Req_Cmd1,
    input  Req_Ready, Done, Busy, D_Addr, D_Wr, RF_s,
           RF_Ra_Addr, RF_Rb_Addr, RF_W_en, RF_W_Addr, ALU_s0
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rr_arbiter2                                                    |
// | Purpose : Two-way round-robin grant selection (combinational).           |
// | Ports   : req[1:0]   in  request vector                                  |
// |           last       in  index of requester served most recently        |
// |           grant[1:0] out one-hot grant, 00 when nothing requested        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: the requester not served last wins.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/datapath_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : datapath_arbiter                                               |
// | Purpose : Accepts commands from two requesters round-robin, latches the  |
// |           accepted command and sequences the datapath controls for       |
// |           NOP / LOAD (two cycles) / STORE / ALU.                         |
// | Ports   : Clock  in  system clock, rising edge                           |
// |           Reset  in  asynchronous active-high reset                      |
// |           bus    datapath_arbiter_if.slave (handshake + controls)        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module datapath_arbiter
  import dp_arb_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  datapath_arbiter_if.slave   bus
);

  state_t     r_state;
  logic       r_prio;    // requester favoured on contention
  logic       r_owner;   // requester whose command is in flight
  cmd_t       r_cmd;
  dp_out_t    r_out;
  logic [1:0] r_done;
  logic       r_busy;

  logic [1:0] w_grant;
  logic [1:0] w_ready;
  logic       w_last;
  logic       w_accept;
  logic       w_idx;
  cmd_t       w_cmd_in;
  state_t     w_next;

  // The arbiter takes "last served"; the favoured requester is its complement,
  // so a reset value of 0 for r_prio lets requester 0 win first.
  assign w_last = ~r_prio;

  rr_arbiter2 u_rr (
    .req   (bus.Req_Valid),
    .last  (w_last),
    .grant (w_grant)
  );

  assign w_ready  = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign w_accept = |w_ready;
  assign w_idx    = w_grant[1];
  assign w_cmd_in = w_idx ? bus.Req_Cmd1 : bus.Req_Cmd0;
  assign w_next   = op_state(w_cmd_in.op);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_cmd   <= '0;
      r_out   <= '0;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd   <= w_cmd_in;
            r_owner <= w_idx;
            r_prio  <= ~w_idx;
            r_state <= w_next;
            r_busy  <= 1'b1;
            // Outputs are registered, so load the controls of the state
            // being entered on the same edge.
            r_out   <= dp_outputs(w_next, w_cmd_in);
            r_done  <= is_final(w_next) ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
          end
        end
        S_LOAD_A: begin
          r_state <= S_LOAD_B;
          r_out   <= dp_outputs(S_LOAD_B, r_cmd);
          r_done  <= r_owner ? 2'b10 : 2'b01;
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
          r_done  <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Req_Ready  = w_ready;
  assign bus.Done       = r_done;
  assign bus.Busy       = r_busy;
  assign bus.D_Addr     = r_out.d_addr;
  assign bus.D_Wr       = r_out.d_wr;
  assign bus.RF_s       = r_out.rf_s;
  assign bus.RF_Ra_Addr = r_out.ra_addr;
  assign bus.RF_Rb_Addr = r_out.rb_addr;
  assign bus.RF_W_en    = r_out.w_en;
  assign bus.RF_W_Addr  = r_out.w_addr;
  assign bus.ALU_s0     = r_out.alu_s;

endmodule
`default_nettype wire
